// File: rtl/alu_md.sv
// alu_md: registered execute-stage ALU with the RISC-V M extension.
//   Base ops complete in one cycle, multiplies in two, divides run a
//   restoring divider (one quotient bit per cycle) followed by a sign-fix
//   cycle. Results sit in a valid/ready output register until retired.
// Ports:
//   clk, rst       clock, asynchronous active-high reset
//   in_valid/in_ready  operand handshake (accept = in_valid & in_ready & !flush)
//   op[4:0]        op[4]=0 base ALU op[3:0]; op[4]=1 M-group funct3 in op[2:0]
//   a, b           XLEN-bit operands
//   flush          squashes the in-flight or held operation at the next edge
//   res_valid/res_ready  result handshake (retire = res_valid & res_ready)
//   res            result register
//   busy           high while in MUL, DIV or FIX
module alu_md #(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic            flush,
    output logic            res_valid,
    input  logic            res_ready,
    output logic [XLEN-1:0] res,
    output logic            busy
);

    localparam int unsigned SHW = $clog2(XLEN);
    localparam int unsigned CW  = SHW + 1;
    localparam int unsigned PW  = 2 * XLEN;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_MUL  = 2'd1;
    localparam logic [1:0] S_DIV  = 2'd2;
    localparam logic [1:0] S_FIX  = 2'd3;

    localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] res_q, res_d;
    logic            res_valid_q, res_valid_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    // quo_q holds operand a for multiplies and the dividend/quotient shift
    // register for divides; div_q holds operand b or the divisor magnitude.
    logic [XLEN-1:0] quo_q, quo_d;
    logic [XLEN-1:0] rem_q, rem_d;
    logic [XLEN-1:0] div_q, div_d;
    logic            mul_hi_q, mul_hi_d;
    logic            a_sx_q, a_sx_d;
    logic            b_sx_q, b_sx_d;
    logic            q_neg_q, q_neg_d;
    logic            r_neg_q, r_neg_d;
    logic            is_rem_q, is_rem_d;

    logic            accept;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] base_res;
    logic            d_signed, a_neg, b_neg, div_zero, div_ovf;
    logic [XLEN-1:0] a_mag, b_mag;
    logic [PW-1:0]   mul_ax, mul_bx, prod;
    logic [XLEN-1:0] mul_res;
    logic [XLEN:0]   partial, diff;
    logic [XLEN-1:0] fix_q, fix_r;
    logic [CW-1:0]   cnt_inc;

    assign in_ready  = (state_q == S_IDLE) && (!res_valid_q || res_ready);
    assign accept    = in_valid && in_ready && !flush;
    assign res       = res_q;
    assign res_valid = res_valid_q;
    assign busy      = (state_q != S_IDLE);

    // Single-cycle base ALU, evaluated on the accept cycle.
    assign shamt = b[SHW-1:0];
    always_comb begin
        base_res = '0;
        case (op[3:0])
            4'b0000: base_res = a + b;
            4'b1000: base_res = a - b;
            4'b0001: base_res = a << shamt;
            4'b0010: base_res = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            4'b0011: base_res = {{(XLEN-1){1'b0}}, (a < b)};
            4'b0100: base_res = a ^ b;
            4'b0101: base_res = a >> shamt;
            4'b1101: base_res = $signed(a) >>> shamt;
            4'b0110: base_res = a | b;
            4'b0111: base_res = a & b;
            default: base_res = '0;
        endcase
    end

    // Divide setup: magnitudes and special-case detection at accept.
    assign d_signed = !op[0];
    assign a_neg    = d_signed && a[XLEN-1];
    assign b_neg    = d_signed && b[XLEN-1];
    assign a_mag    = a_neg ? (XLEN'(0) - a) : a;
    assign b_mag    = b_neg ? (XLEN'(0) - b) : b;
    assign div_zero = (b == '0);
    assign div_ovf  = d_signed && (a == MIN_VAL) && (b == '1);

    // Extending to 2*XLEN and keeping the low 2*XLEN product bits gives the
    // exact product for every signed/unsigned operand combination.
    assign mul_ax  = {{XLEN{a_sx_q && quo_q[XLEN-1]}}, quo_q};
    assign mul_bx  = {{XLEN{b_sx_q && div_q[XLEN-1]}}, div_q};
    assign prod    = mul_ax * mul_bx;
    assign mul_res = mul_hi_q ? prod[PW-1:XLEN] : prod[XLEN-1:0];

    // One restoring step: shift next dividend bit in, subtract if it fits.
    assign partial = {rem_q, quo_q[XLEN-1]};
    assign diff    = partial - {1'b0, div_q};
    assign cnt_inc = cnt_q + CW'(1);

    assign fix_q = q_neg_q ? (XLEN'(0) - quo_q) : quo_q;
    assign fix_r = r_neg_q ? (XLEN'(0) - rem_q) : rem_q;

    // Next-state and datapath control.
    always_comb begin
        state_d     = state_q;
        res_d       = res_q;
        res_valid_d = res_valid_q && !res_ready;
        cnt_d       = cnt_q;
        quo_d       = quo_q;
        rem_d       = rem_q;
        div_d       = div_q;
        mul_hi_d    = mul_hi_q;
        a_sx_d      = a_sx_q;
        b_sx_d      = b_sx_q;
        q_neg_d     = q_neg_q;
        r_neg_d     = r_neg_q;
        is_rem_d    = is_rem_q;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (!op[4]) begin
                        res_d       = base_res;
                        res_valid_d = 1'b1;
                    end else if (!op[2]) begin
                        state_d  = S_MUL;
                        quo_d    = a;
                        div_d    = b;
                        mul_hi_d = (op[1:0] != 2'b00);
                        a_sx_d   = (op[1:0] == 2'b01) || (op[1:0] == 2'b10);
                        b_sx_d   = (op[1:0] == 2'b01);
                    end else begin
                        is_rem_d = op[1];
                        cnt_d    = '0;
                        if (div_zero) begin
                            state_d = S_FIX;
                            quo_d   = '1;
                            rem_d   = a;
                            q_neg_d = 1'b0;
                            r_neg_d = 1'b0;
                        end else if (div_ovf) begin
                            state_d = S_FIX;
                            quo_d   = MIN_VAL;
                            rem_d   = '0;
                            q_neg_d = 1'b0;
                            r_neg_d = 1'b0;
                        end else begin
                            state_d = S_DIV;
                            quo_d   = a_mag;
                            rem_d   = '0;
                            div_d   = b_mag;
                            q_neg_d = a_neg ^ b_neg;
                            r_neg_d = a_neg;
                        end
                    end
                end
            end
            S_MUL: begin
                res_d       = mul_res;
                res_valid_d = 1'b1;
                state_d     = S_IDLE;
            end
            S_DIV: begin
                if (!diff[XLEN]) begin
                    rem_d = diff[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b1};
                end else begin
                    rem_d = partial[XLEN-1:0];
                    quo_d = {quo_q[XLEN-2:0], 1'b0};
                end
                cnt_d = cnt_inc;
                if (cnt_inc == CW'(XLEN)) begin
                    state_d = S_FIX;
                end
            end
            S_FIX: begin
                res_d       = is_rem_q ? fix_r : fix_q;
                res_valid_d = 1'b1;
                state_d     = S_IDLE;
                cnt_d       = '0;
            end
            default: state_d = S_IDLE;
        endcase

        // Flush wins over any accept or completion in the same cycle.
        if (flush) begin
            state_d     = S_IDLE;
            res_d       = res_q;
            res_valid_d = 1'b0;
            cnt_d       = '0;
        end
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            res_q       <= '0;
            res_valid_q <= 1'b0;
            cnt_q       <= '0;
            quo_q       <= '0;
            rem_q       <= '0;
            div_q       <= '0;
            mul_hi_q    <= 1'b0;
            a_sx_q      <= 1'b0;
            b_sx_q      <= 1'b0;
            q_neg_q     <= 1'b0;
            r_neg_q     <= 1'b0;
            is_rem_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            res_q       <= res_d;
            res_valid_q <= res_valid_d;
            cnt_q       <= cnt_d;
            quo_q       <= quo_d;
            rem_q       <= rem_d;
            div_q       <= div_d;
            mul_hi_q    <= mul_hi_d;
            a_sx_q      <= a_sx_d;
            b_sx_q      <= b_sx_d;
            q_neg_q     <= q_neg_d;
            r_neg_q     <= r_neg_d;
            is_rem_q    <= is_rem_d;
        end
    end

endmodule

// File: tb/tb_alu_md.sv
// Testbench for alu_md: directed vector table, hand-written handshake and
// flush/reset sequences, and randomized ops against an arithmetic model.
// Two instances: XLEN=32 (main) and XLEN=8 (parameter sweep).
module tb_alu_md;

    logic        clk;
    logic        rst, in_valid, flush, res_ready;
    logic [4:0]  op;
    logic [31:0] a, b, res;
    logic        in_ready, res_valid, busy;

    logic        rst8, in_valid8, flush8, res_ready8;
    logic [4:0]  op8;
    logic [7:0]  a8, b8, res8;
    logic        in_ready8, res_valid8, busy8;

    int checks;
    int failures;

    localparam logic [31:0] MIN32 = 32'h8000_0000;

    alu_md #(.XLEN(32)) u_dut32 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .flush(flush), .res_valid(res_valid),
        .res_ready(res_ready), .res(res), .busy(busy)
    );

    alu_md #(.XLEN(8)) u_dut8 (
        .clk(clk), .rst(rst8), .in_valid(in_valid8), .in_ready(in_ready8),
        .op(op8), .a(a8), .b(b8), .flush(flush8), .res_valid(res_valid8),
        .res_ready(res_ready8), .res(res8), .busy(busy8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Reference model: results from RISC-V arithmetic rules on 32/64-bit ints.
    function automatic logic [31:0] model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        int sx;
        int sy;
        int unsigned sh;
        logic [63:0] p;
        sx = x;
        sy = y;
        sh = int'(y[4:0]);
        if (!o[4]) begin
            case (o[3:0])
                4'b0000: return x + y;
                4'b1000: return x - y;
                4'b0001: return x << sh;
                4'b0010: return (sx < sy) ? 32'd1 : 32'd0;
                4'b0011: return (x < y) ? 32'd1 : 32'd0;
                4'b0100: return x ^ y;
                4'b0101: return x >> sh;
                4'b1101: return 32'(sx >>> sh);
                4'b0110: return x | y;
                4'b0111: return x & y;
                default: return 32'd0;
            endcase
        end
        case (o[2:0])
            3'd0: return x * y;
            3'd1: begin p = 64'(longint'(sx) * longint'(sy)); return p[63:32]; end
            3'd2: begin p = 64'(longint'(sx) * longint'({32'd0, y})); return p[63:32]; end
            3'd3: begin p = {32'd0, x} * {32'd0, y}; return p[63:32]; end
            3'd4: begin
                if (y == 32'd0) return 32'hFFFF_FFFF;
                if (x == MIN32 && y == 32'hFFFF_FFFF) return MIN32;
                return 32'(sx / sy);
            end
            3'd5: return (y == 32'd0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 32'd0) return x;
                if (x == MIN32 && y == 32'hFFFF_FFFF) return 32'd0;
                return 32'(sx % sy);
            end
            default: return (y == 32'd0) ? x : x % y;
        endcase
    endfunction

    function automatic int model_lat(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        if (!o[4]) return 1;
        if (!o[2]) return 2;
        if (y == 32'd0) return 2;
        if (!o[0] && x == MIN32 && y == 32'hFFFF_FFFF) return 2;
        return 34;
    endfunction

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return MIN32;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Issue one op on the 32-bit unit and check result, latency, busy time
    // and in_ready right after accept. res_ready is held high by the caller.
    task automatic run_op(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y,
                          input logic [31:0] exp_res, input int exp_lat, input string name);
        int guard;
        int lat;
        int busy_cycles;
        logic first_ready;
        guard = 0;
        while (!in_ready && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        chk({name, "_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        op = o;
        a = x;
        b = y;
        @(posedge clk); #1;
        in_valid = 1'b0;
        op = 5'($urandom);
        a = $urandom;
        b = $urandom;
        first_ready = in_ready;
        lat = 1;
        busy_cycles = 0;
        while (!res_valid && lat < 200) begin
            if (busy) busy_cycles++;
            @(posedge clk); #1;
            lat++;
        end
        chk({name, "_res"}, res, exp_res);
        chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
        chk({name, "_busy"}, 32'(busy_cycles), 32'(exp_lat - 1));
        chk({name, "_inrdy"}, 32'(first_ready), (exp_lat == 1) ? 32'd1 : 32'd0);
    endtask

    task automatic run_op8(input logic [4:0] o, input logic [7:0] x, input logic [7:0] y,
                           input logic [7:0] exp_res, input int exp_lat, input string name);
        int lat;
        in_valid8 = 1'b1;
        op8 = o;
        a8 = x;
        b8 = y;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        lat = 1;
        while (!res_valid8 && lat < 100) begin
            @(posedge clk); #1;
            lat++;
        end
        chk({name, "_res"}, 32'(res8), 32'(exp_res));
        chk({name, "_lat"}, 32'(lat), 32'(exp_lat));
    endtask

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_res;
        int          lat;
    } vec_t;

    vec_t tbl[20];

    initial begin
        int seen;
        checks = 0;
        failures = 0;

        tbl[0]  = '{5'b00000, 32'd7,          32'hFFFF_FFFD, 32'd4,          1};
        tbl[1]  = '{5'b01101, 32'h8000_0000,  32'd4,         32'hF800_0000,  1};
        tbl[2]  = '{5'b00011, 32'd1,          32'hFFFF_FFFF, 32'd1,          1};
        tbl[3]  = '{5'b01000, 32'd5,          32'd7,         32'hFFFF_FFFE,  1};
        tbl[4]  = '{5'b00010, 32'hFFFF_FFFF,  32'd1,         32'd1,          1};
        tbl[5]  = '{5'b01001, 32'd123,        32'd456,       32'd0,          1};
        tbl[6]  = '{5'b10001, 32'hFFFF_FFFE,  32'd3,         32'hFFFF_FFFF,  2};
        tbl[7]  = '{5'b10011, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE,  2};
        tbl[8]  = '{5'b10000, 32'h0001_0000,  32'h0001_0000, 32'd0,          2};
        tbl[9]  = '{5'b10010, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF,  2};
        tbl[10] = '{5'b10100, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD,  34};
        tbl[11] = '{5'b10110, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF,  34};
        tbl[12] = '{5'b10101, 32'd100,        32'd7,         32'd14,         34};
        tbl[13] = '{5'b10111, 32'd100,        32'd7,         32'd2,          34};
        tbl[14] = '{5'b10100, 32'd5,          32'd0,         32'hFFFF_FFFF,  2};
        tbl[15] = '{5'b10111, 32'd5,          32'd0,         32'd5,          2};
        tbl[16] = '{5'b10100, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000,  2};
        tbl[17] = '{5'b10110, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,          2};
        tbl[18] = '{5'b11000, 32'd6,          32'd7,         32'd42,         2};
        tbl[19] = '{5'b10110, 32'd7,          32'hFFFF_FFFE, 32'd1,          34};

        rst = 1'b1;      rst8 = 1'b1;
        in_valid = 1'b0; in_valid8 = 1'b0;
        flush = 1'b0;    flush8 = 1'b0;
        res_ready = 1'b1; res_ready8 = 1'b1;
        op = '0; a = '0; b = '0;
        op8 = '0; a8 = '0; b8 = '0;

        repeat (3) @(posedge clk);
        #1;
        chk("reset_res", res, 32'd0);
        chk("reset_valid", 32'(res_valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_inready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        rst8 = 1'b0;
        @(posedge clk); #1;

        // Back-to-back base ops: retire and new result in the same cycle.
        in_valid = 1'b1; op = 5'b00000; a = 32'd7; b = 32'hFFFF_FFFD;
        @(posedge clk); #1;
        chk("b2b_add", res, 32'd4);
        chk("b2b_add_v", 32'(res_valid), 32'd1);
        op = 5'b01101; a = 32'h8000_0000; b = 32'd4;
        @(posedge clk); #1;
        chk("b2b_sra", res, 32'hF800_0000);
        chk("b2b_sra_v", 32'(res_valid), 32'd1);
        op = 5'b00011; a = 32'd1; b = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        chk("b2b_sltu", res, 32'd1);
        chk("b2b_sltu_v", 32'(res_valid), 32'd1);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("b2b_drain", 32'(res_valid), 32'd0);

        for (int i = 0; i < 20; i++) begin
            run_op(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp_res, tbl[i].lat,
                   $sformatf("vec%0d", i));
        end

        // Backpressure: result held, second input refused.
        @(posedge clk); #1;
        res_ready = 1'b0;
        in_valid = 1'b1; op = 5'b00000; a = 32'd2; b = 32'd3;
        @(posedge clk); #1;
        chk("bp_res", res, 32'd5);
        chk("bp_valid", 32'(res_valid), 32'd1);
        chk("bp_inready", 32'(in_ready), 32'd0);
        a = 32'd9; b = 32'd9;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("bp_hold_res", res, 32'd5);
        chk("bp_hold_valid", 32'(res_valid), 32'd1);
        chk("bp_hold_inready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        res_ready = 1'b1;
        #1;
        chk("bp_release_inready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        chk("bp_retired", 32'(res_valid), 32'd0);

        // Flush at divide iteration 10 with a simultaneous input.
        in_valid = 1'b1; op = 5'b10100; a = 32'd1000; b = 32'd3;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
        end
        chk("fl_busy_before", 32'(busy), 32'd1);
        flush = 1'b1;
        in_valid = 1'b1; op = 5'b00000; a = 32'd1; b = 32'd1;
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_valid", 32'(res_valid), 32'd0);
        chk("fl_busy", 32'(busy), 32'd0);
        chk("fl_inready", 32'(in_ready), 32'd1);
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (res_valid) seen++;
        end
        chk("fl_no_result", 32'(seen), 32'd0);

        // Flush in IDLE beats an accept.
        flush = 1'b1;
        in_valid = 1'b1; op = 5'b00000; a = 32'd1; b = 32'd1;
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        chk("fl_idle_valid", 32'(res_valid), 32'd0);

        // Randomized ops against the model.
        for (int i = 0; i < 150; i++) begin
            logic [4:0]  ro;
            logic [31:0] ra;
            logic [31:0] rb;
            if ($urandom_range(0, 2) == 0) ro = {1'b0, 4'($urandom)};
            else ro = {1'b1, 4'($urandom)};
            ra = pick_operand();
            rb = pick_operand();
            run_op(ro, ra, rb, model(ro, ra, rb), model_lat(ro, ra, rb),
                   $sformatf("rnd%0d_op%0h", i, ro));
        end

        // XLEN=8 sweep.
        run_op8(5'b00001, 8'd1, 8'd9, 8'd2, 1, "x8_sll");
        run_op8(5'b10101, 8'd200, 8'd3, 8'd66, 10, "x8_divu");
        @(posedge clk); #1;
        in_valid8 = 1'b1; op8 = 5'b10101; a8 = 8'd200; b8 = 8'd3;
        @(posedge clk); #1;
        in_valid8 = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("x8_busy_mid", 32'(busy8), 32'd1);
        rst8 = 1'b1;
        #1;
        chk("x8_rst_res", 32'(res8), 32'd0);
        chk("x8_rst_valid", 32'(res_valid8), 32'd0);
        chk("x8_rst_busy", 32'(busy8), 32'd0);
        chk("x8_rst_inready", 32'(in_ready8), 32'd1);
        @(posedge clk); #1;
        rst8 = 1'b0;
        seen = 0;
        repeat (15) begin
            @(posedge clk); #1;
            if (res_valid8) seen++;
        end
        chk("x8_rst_no_result", 32'(seen), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
